// File: rtl/stepper_pkg.sv
// Shared constants and FSM state type for the stepper move sequencer.
package stepper_pkg;

    localparam logic [1:0] ADDR_CTRL    = 2'd0;
    localparam logic [1:0] ADDR_STEPS   = 2'd1;
    localparam logic [1:0] ADDR_HALFPER = 2'd2;
    localparam logic [1:0] ADDR_STATUS  = 2'd3;

    localparam int unsigned CTRL_START = 0;
    localparam int unsigned CTRL_ABORT = 1;
    localparam int unsigned CTRL_DIR   = 2;
    localparam int unsigned CTRL_MS1   = 3;
    localparam int unsigned CTRL_MS2   = 4;

    localparam int unsigned MIN_HALFPER = 2;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StHigh,
        StLow,
        StDone
    } state_e;

endpackage

// File: rtl/stepper_move_sequencer_if.sv
// APB3 bus bundle between the fabric master and the stepper sequencer.
interface stepper_move_sequencer_if;

    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/stepper_rate_timer.sv
// Loadable down-counter; expire is high while the count sits at zero, so a load
// of N keeps the owning state active for N+1 cycles.
module stepper_rate_timer #(
    parameter int unsigned PER_W = 16
) (
    input  logic             PCLK,
    input  logic             PRESERN,
    input  logic             load,
    input  logic [PER_W-1:0] value,
    output logic             expire
);

    logic [PER_W-1:0] cnt_q;

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= value;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - PER_W'(1);
        end
    end

    assign expire = (cnt_q == '0);

endmodule

// File: rtl/stepper_move_sequencer.sv
// APB3 slave that issues a programmed burst of STEP pulses to one stepper driver,
// honouring the direction-dependent limit switch before every pulse.
module stepper_move_sequencer
    import stepper_pkg::*;
#(
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned PER_W     = 16,
    parameter int unsigned DIR_SETUP = 8
) (
    input  logic                     PCLK,
    input  logic                     PRESERN,
    stepper_move_sequencer_if.slave  apb,
    output logic                     MS1,
    output logic                     MS2,
    output logic                     DIR,
    output logic                     STEP,
    input  logic                     SW,
    input  logic                     SW2
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] steps_q, rem_q, rem_d;
    logic [PER_W-1:0] halfper_q, hp_eff, hp_load, tmr_value;
    logic             done_q, done_d, lim_q, lim_d;
    logic             dir_q, dir_d, step_q;
    logic [1:0]       ms_q, ms_d;
    logic             sw_meta_q, sw_sync_q, sw2_meta_q, sw2_sync_q;
    logic             tmr_load, tmr_expire, limit_hit, busy;
    logic             wr_en, wr_ctrl, rd_setup, start_req, abort_req;
    logic [1:0]       addr;
    logic [31:0]      rdata, prdata_q;
    logic             unused_apb;

    assign addr      = apb.PADDR[3:2];
    assign wr_en     = apb.PSEL & apb.PENABLE & apb.PWRITE;
    assign rd_setup  = apb.PSEL & ~apb.PENABLE & ~apb.PWRITE;
    assign wr_ctrl   = wr_en && (addr == ADDR_CTRL);
    // ABORT in the same write suppresses START.
    assign start_req = wr_ctrl & apb.PWDATA[CTRL_START] & ~apb.PWDATA[CTRL_ABORT];
    assign abort_req = wr_ctrl & apb.PWDATA[CTRL_ABORT];
    assign busy      = (state_q != StIdle);

    assign apb.PREADY  = 1'b1;
    assign apb.PSLVERR = 1'b0;
    assign apb.PRDATA  = prdata_q;
    assign unused_apb  = ^{apb.PADDR[31:4], apb.PADDR[1:0], apb.PWDATA};

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            sw_meta_q  <= 1'b0;
            sw_sync_q  <= 1'b0;
            sw2_meta_q <= 1'b0;
            sw2_sync_q <= 1'b0;
        end else begin
            sw_meta_q  <= SW;
            sw_sync_q  <= sw_meta_q;
            sw2_meta_q <= SW2;
            sw2_sync_q <= sw2_meta_q;
        end
    end

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            steps_q   <= '0;
            halfper_q <= '0;
        end else if (wr_en && !busy) begin
            if (addr == ADDR_STEPS)   steps_q   <= apb.PWDATA[CNT_W-1:0];
            if (addr == ADDR_HALFPER) halfper_q <= apb.PWDATA[PER_W-1:0];
        end
    end

    assign hp_eff    = (halfper_q < PER_W'(MIN_HALFPER)) ? PER_W'(MIN_HALFPER) : halfper_q;
    assign hp_load   = hp_eff - PER_W'(1);
    assign limit_hit = dir_q ? sw_sync_q : sw2_sync_q;

    stepper_rate_timer #(
        .PER_W (PER_W)
    ) u_timer (
        .PCLK    (PCLK),
        .PRESERN (PRESERN),
        .load    (tmr_load),
        .value   (tmr_value),
        .expire  (tmr_expire)
    );

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        done_d    = done_q;
        lim_d     = lim_q;
        dir_d     = dir_q;
        ms_d      = ms_q;
        tmr_load  = 1'b0;
        tmr_value = '0;
        unique case (state_q)
            StIdle: begin
                if (start_req) begin
                    if (steps_q != '0) begin
                        state_d   = StSetup;
                        dir_d     = apb.PWDATA[CTRL_DIR];
                        ms_d      = {apb.PWDATA[CTRL_MS2], apb.PWDATA[CTRL_MS1]};
                        rem_d     = steps_q;
                        done_d    = 1'b0;
                        lim_d     = 1'b0;
                        tmr_load  = 1'b1;
                        tmr_value = PER_W'(DIR_SETUP);
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            StSetup, StLow: begin
                if (abort_req) begin
                    state_d = StDone;
                end else if (tmr_expire) begin
                    // Limit is sampled just before a pulse would start.
                    if (state_q == StLow && rem_q == '0) begin
                        state_d = StDone;
                    end else if (limit_hit) begin
                        lim_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        state_d   = StHigh;
                        tmr_load  = 1'b1;
                        tmr_value = hp_load;
                    end
                end
            end
            StHigh: begin
                if (abort_req) begin
                    state_d = StDone;
                end else if (tmr_expire) begin
                    state_d   = StLow;
                    tmr_load  = 1'b1;
                    tmr_value = hp_load;
                    if (rem_q != '0) rem_d = rem_q - CNT_W'(1);
                end
            end
            StDone: begin
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            state_q <= StIdle;
            rem_q   <= '0;
            done_q  <= 1'b0;
            lim_q   <= 1'b0;
            dir_q   <= 1'b0;
            ms_q    <= 2'b00;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
            lim_q   <= lim_d;
            dir_q   <= dir_d;
            ms_q    <= ms_d;
            step_q  <= (state_d == StHigh);
        end
    end

    assign DIR  = dir_q;
    assign MS1  = ms_q[0];
    assign MS2  = ms_q[1];
    assign STEP = step_q;

    always_comb begin
        rdata = '0;
        case (addr)
            ADDR_STEPS:   rdata = 32'(steps_q);
            ADDR_HALFPER: rdata = 32'(halfper_q);
            ADDR_STATUS: begin
                rdata[0]     = busy;
                rdata[1]     = done_q;
                rdata[2]     = lim_q;
                rdata[3]     = sw_sync_q;
                rdata[4]     = sw2_sync_q;
                rdata[31:16] = 16'(rem_q);
            end
            default:      rdata = '0;
        endcase
    end

    // Captured in the setup phase so PRDATA is stable throughout the access phase.
    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            prdata_q <= '0;
        end else if (rd_setup) begin
            prdata_q <= rdata;
        end
    end

endmodule

// File: tb/tb_stepper_move_sequencer.sv
// Self-checking bench for stepper_move_sequencer: register table, directed corner
// sequences and randomized moves against an arithmetic pulse-train model.
module tb_stepper_move_sequencer;

    localparam int DS = 8;
    localparam logic [31:0] A_CTRL = 32'h0;
    localparam logic [31:0] A_STEPS = 32'h4;
    localparam logic [31:0] A_HP = 32'h8;
    localparam logic [31:0] A_STAT = 32'hC;

    logic pclk = 1'b0;
    logic presern = 1'b0;
    logic ms1, ms2, dir, step;
    logic sw = 1'b0;
    logic sw2 = 1'b0;

    stepper_move_sequencer_if apb_if ();

    stepper_move_sequencer #(
        .CNT_W     (16),
        .PER_W     (16),
        .DIR_SETUP (DS)
    ) dut (
        .PCLK    (pclk),
        .PRESERN (presern),
        .apb     (apb_if),
        .MS1     (ms1),
        .MS2     (ms2),
        .DIR     (dir),
        .STEP    (step),
        .SW      (sw),
        .SW2     (sw2)
    );

    always #5 pclk = ~pclk;

    int n_vec = 0;
    int n_mis = 0;
    int cyc = 0;
    int rise_q[$];
    int fall_q[$];
    logic step_prev = 1'b0;

    always @(posedge pclk) cyc <= cyc + 1;

    always @(negedge pclk) begin
        if (step && !step_prev) rise_q.push_back(cyc);
        if (!step && step_prev) fall_q.push_back(cyc);
        step_prev <= step;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", n_vec);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
        apb_if.PSEL = 1'b1;
        apb_if.PENABLE = 1'b0;
        apb_if.PWRITE = 1'b1;
        apb_if.PADDR = addr;
        apb_if.PWDATA = data;
        @(posedge pclk);
        #1 apb_if.PENABLE = 1'b1;
        @(posedge pclk);
        #1 apb_if.PSEL = 1'b0;
        apb_if.PENABLE = 1'b0;
        apb_if.PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] addr, output logic [31:0] data);
        apb_if.PSEL = 1'b1;
        apb_if.PENABLE = 1'b0;
        apb_if.PWRITE = 1'b0;
        apb_if.PADDR = addr;
        @(posedge pclk);
        #1 apb_if.PENABLE = 1'b1;
        data = apb_if.PRDATA;
        @(posedge pclk);
        #1 apb_if.PSEL = 1'b0;
        apb_if.PENABLE = 1'b0;
    endtask

    task automatic wait_rises(input int cnt, input string tag);
        int budget = 0;
        while (rise_q.size() < cnt && budget < 3000) begin
            @(posedge pclk);
            #1;
            budget++;
        end
        check({tag, ":pulse_wait"}, 32'(rise_q.size() >= cnt), 32'd1);
    endtask

    // Model: pulse k rises DS+1+2*hpe*k cycles after the START write, falls hpe later.
    task automatic run_move(input int n, input int hp_raw, input bit d, input bit [1:0] ms,
                            input string tag);
        int w, hpe;
        logic [31:0] r;
        hpe = (hp_raw < 2) ? 2 : hp_raw;
        apb_write(A_STEPS, n);
        apb_write(A_HP, hp_raw);
        rise_q.delete();
        fall_q.delete();
        apb_write(A_CTRL, 32'({ms, d, 2'b01}));
        w = cyc;
        apb_read(A_STAT, r);
        check({tag, ":busy"}, 32'(r[0]), 32'd1);
        repeat (DS + 4 + 2 * hpe * n) @(posedge pclk);
        #1;
        check({tag, ":dir"}, 32'(dir), 32'(d));
        check({tag, ":ms2"}, 32'(ms2), 32'(ms[1]));
        check({tag, ":ms1"}, 32'(ms1), 32'(ms[0]));
        check({tag, ":rises"}, rise_q.size(), n);
        check({tag, ":falls"}, fall_q.size(), n);
        for (int k = 0; k < n && k < rise_q.size(); k++)
            check({tag, ":rise_t"}, rise_q[k], w + DS + 1 + 2 * hpe * k);
        for (int k = 0; k < n && k < fall_q.size(); k++)
            check({tag, ":fall_t"}, fall_q[k], w + DS + 1 + 2 * hpe * k + hpe);
        apb_read(A_STAT, r);
        check({tag, ":status"}, r, 32'h2 | (32'(sw) << 3) | (32'(sw2) << 4));
    endtask

    typedef struct {
        bit          do_write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        string       name;
    } reg_vec_t;

    reg_vec_t tbl[7];

    initial begin
        logic [31:0] r;
        int a;

        tbl[0] = '{1'b0, A_STAT, 32'h0, 32'h0, "status_after_reset"};
        tbl[1] = '{1'b1, A_STEPS, 32'h0000_1234, 32'h0000_1234, "steps_rw"};
        tbl[2] = '{1'b1, A_STEPS, 32'hFFFF_ABCD, 32'h0000_ABCD, "steps_width"};
        tbl[3] = '{1'b1, A_HP, 32'h0, 32'h0, "halfper_zero_raw"};
        tbl[4] = '{1'b1, A_HP, 32'h77, 32'h77, "halfper_rw"};
        tbl[5] = '{1'b1, A_CTRL, 32'h1C, 32'h0, "ctrl_reads_zero"};
        tbl[6] = '{1'b0, A_STAT, 32'h0, 32'h0, "ctrl_no_start_idle"};

        apb_if.PSEL = 1'b0;
        apb_if.PENABLE = 1'b0;
        apb_if.PWRITE = 1'b0;
        apb_if.PADDR = '0;
        apb_if.PWDATA = '0;
        repeat (3) @(posedge pclk);
        #1;
        check("rst:step", 32'(step), 0);
        check("rst:dir", 32'(dir), 0);
        check("rst:ms", 32'({ms2, ms1}), 0);
        check("rst:prdata", apb_if.PRDATA, 0);
        check("rst:pready", 32'(apb_if.PREADY), 1);
        check("rst:pslverr", 32'(apb_if.PSLVERR), 0);
        presern = 1'b1;
        @(posedge pclk);
        #1;

        for (int i = 0; i < 7; i++) begin
            if (tbl[i].do_write) apb_write(tbl[i].addr, tbl[i].wdata);
            apb_read(tbl[i].addr, r);
            check(tbl[i].name, r, tbl[i].exp);
        end

        // Asynchronous reset in the middle of a HIGH phase.
        apb_write(A_STEPS, 5);
        apb_write(A_HP, 6);
        rise_q.delete();
        fall_q.delete();
        apb_write(A_CTRL, 32'h1D);
        wait_rises(1, "rstmid");
        apb_read(A_STAT, r);
        check("rstmid:status_busy", r, 32'h0005_0001);
        check("rstmid:step_high", 32'(step), 1);
        presern = 1'b0;
        #1;
        check("rstmid:step", 32'(step), 0);
        check("rstmid:prdata", apb_if.PRDATA, 0);
        check("rstmid:dir_ms", 32'({dir, ms2, ms1}), 0);
        @(posedge pclk);
        #1 presern = 1'b1;
        apb_read(A_STAT, r);
        check("rstmid:status", r, 0);
        repeat (30) @(posedge pclk);
        #1;
        check("rstmid:no_more_pulses", rise_q.size(), 1);

        // START with STEPS=0: done after one cycle, no pulses.
        apb_write(A_STEPS, 0);
        rise_q.delete();
        apb_write(A_CTRL, 32'h5);
        apb_read(A_STAT, r);
        check("zero:status", r, 32'h2);
        repeat (20) @(posedge pclk);
        #1;
        check("zero:no_pulses", rise_q.size(), 0);

        run_move(3, 5, 1'b1, 2'b10, "basic");

        // Forward limit during pulse 10 of 100.
        apb_write(A_STEPS, 100);
        apb_write(A_HP, 4);
        rise_q.delete();
        fall_q.delete();
        apb_write(A_CTRL, 32'h5);
        wait_rises(10, "limit");
        sw = 1'b1;
        repeat (40) @(posedge pclk);
        #1;
        check("limit:rises", rise_q.size(), 10);
        check("limit:falls", fall_q.size(), 10);
        apb_read(A_STAT, r);
        check("limit:status", r, 32'h005A_000E);

        // Reverse move ignores SW, stops on SW2.
        repeat (3) @(posedge pclk);
        #1;
        run_move(4, 3, 1'b0, 2'b01, "rev_sw");
        sw = 1'b0;
        sw2 = 1'b1;
        repeat (3) @(posedge pclk);
        #1;
        apb_write(A_STEPS, 3);
        apb_write(A_HP, 3);
        rise_q.delete();
        apb_write(A_CTRL, 32'h1);
        repeat (DS + 10) @(posedge pclk);
        #1;
        check("rev_sw2:rises", rise_q.size(), 0);
        apb_read(A_STAT, r);
        check("rev_sw2:status", r, 32'h0003_0016);
        sw2 = 1'b0;
        repeat (3) @(posedge pclk);
        #1;

        // ABORT in the third HIGH; a HALFPER write while busy must be dropped.
        apb_write(A_STEPS, 10);
        apb_write(A_HP, 8);
        rise_q.delete();
        fall_q.delete();
        apb_write(A_CTRL, 32'h5);
        wait_rises(3, "abort");
        apb_write(A_HP, 9);
        apb_write(A_CTRL, 32'h2);
        a = cyc;
        check("abort:step_low", 32'(step), 0);
        @(negedge pclk);
        #1;
        check("abort:falls", fall_q.size(), 3);
        if (fall_q.size() >= 3) check("abort:fall_t", fall_q[2], a);
        repeat (30) @(posedge pclk);
        #1;
        check("abort:rises", rise_q.size(), 3);
        apb_read(A_STAT, r);
        check("abort:status", r, 32'h0008_0002);
        apb_read(A_HP, r);
        check("abort:halfper_kept", r, 8);

        run_move(2, 0, 1'b1, 2'b11, "hp0");

        for (int i = 0; i < 6; i++) begin
            run_move(int'($urandom_range(1, 5)), int'($urandom_range(0, 5)),
                     1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
